// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the load/store unit
package mips_mem_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic {
        LSU_IDLE      = 1'b0,
        LSU_RMW_WRITE = 1'b1
    } lsu_state_t;

    // Raw CPU size code to access width; the reserved code behaves as a word.
    function automatic mem_size_t decode_size(input logic [1:0] raw);
        case (raw)
            2'd0:    return MEM_BYTE;
            2'd1:    return MEM_HALF;
            default: return MEM_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - little-endian byte-lane extract and merge (combinational)
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  rd_off,
    input  logic [1:0]  rd_size,
    input  logic        rd_signed,
    output logic [31:0] rdata,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  wr_off,
    input  logic [1:0]  wr_size,
    output logic [31:0] merged
);

    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] mask;
    logic [31:0] placed;

    // Load path: shift the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted = rd_word >> {rd_off, 3'b000};
        case (mem_size_t'(rd_size))
            MEM_BYTE: rdata = {{24{rd_signed & shifted[7]}}, shifted[7:0]};
            MEM_HALF: rdata = {{16{rd_signed & shifted[15]}}, shifted[15:0]};
            default:  rdata = rd_word;
        endcase
    end

    // Store path: new lanes replace old ones, untouched lanes are kept.
    always_comb begin
        case (mem_size_t'(wr_size))
            MEM_BYTE: lane_mask = 32'h0000_00FF;
            MEM_HALF: lane_mask = 32'h0000_FFFF;
            default:  lane_mask = 32'hFFFF_FFFF;
        endcase
        mask   = lane_mask << {wr_off, 3'b000};
        placed = wdata << {wr_off, 3'b000};
        merged = (old_word & ~mask) | (placed & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - CPU byte/half/word loads and stores onto a word-wide data_ram
// Optional: MISALIGN_TRAP_EN makes misaligned accesses return resp_err instead of force-aligning.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter int WORD_AW = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_address,
    output logic        ram_read,
    output logic        ram_write,
    output logic [31:0] ram_writedata,
    input  logic [31:0] ram_readdata
);

    lsu_state_t         state;
    lsu_state_t         state_next;
    mem_size_t          req_sz;
    logic [1:0]         req_off;
    logic               trap;
    logic               accept;
    logic               go;
    logic               sub_store;
    logic [WORD_AW-1:0] req_word;
    logic [WORD_AW-1:0] cur_word;
    logic [WORD_AW-1:0] last_word;
    logic [WORD_AW-1:0] rmw_word;
    logic [31:0]        rmw_old;
    logic [31:0]        rmw_wdata;
    logic [1:0]         rmw_off;
    logic [1:0]         rmw_size;
    logic [31:0]        ext_rdata;
    logic [31:0]        merged;
    logic               unused_addr_bits;

    assign req_sz           = decode_size(req_size);
    assign req_word         = req_addr[WORD_AW+1:2];
    assign unused_addr_bits = ^req_addr[31:WORD_AW+2];

    // Offsets are always force-aligned; in trap builds misaligned ones never reach the RAM.
    assign req_off = (req_sz == MEM_WORD) ? 2'b00 :
                     (req_sz == MEM_HALF) ? {req_addr[1], 1'b0} : req_addr[1:0];

`ifdef MISALIGN_TRAP_EN
    assign trap = ((req_sz == MEM_HALF) && req_addr[0]) ||
                  ((req_sz == MEM_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    assign busy      = (state != LSU_IDLE);
    assign accept    = req_valid & ~busy & ~reset;
    assign go        = accept & ~trap;
    assign sub_store = go & req_we & (req_sz != MEM_WORD);

    lsu_lane_align u_lane_align (
        .rd_word   (ram_readdata),
        .rd_off    (req_off),
        .rd_size   (req_sz),
        .rd_signed (req_signed),
        .rdata     (ext_rdata),
        .old_word  (rmw_old),
        .wdata     (rmw_wdata),
        .wr_off    (rmw_off),
        .wr_size   (rmw_size),
        .merged    (merged)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= LSU_IDLE;
        else       state <= state_next;
    end

    // Next state: only a sub-word store needs the extra write cycle.
    always_comb begin
        state_next = state;
        case (state)
            LSU_IDLE:      if (sub_store) state_next = LSU_RMW_WRITE;
            LSU_RMW_WRITE: state_next = LSU_IDLE;
            default:       state_next = LSU_IDLE;
        endcase
    end

    // RAM strobes and address; the address parks on the last access when idle.
    always_comb begin
        ram_read      = 1'b0;
        ram_write     = 1'b0;
        ram_writedata = 32'h0;
        cur_word      = last_word;
        case (state)
            LSU_IDLE: begin
                if (go) begin
                    cur_word = req_word;
                    if (req_we && (req_sz == MEM_WORD)) begin
                        ram_write     = 1'b1;
                        ram_writedata = req_wdata;
                    end else begin
                        ram_read = 1'b1;
                    end
                end
            end
            LSU_RMW_WRITE: begin
                cur_word      = rmw_word;
                ram_write     = ~reset;
                ram_writedata = merged;
            end
            default: ;
        endcase
    end

    assign ram_address = {{(32-WORD_AW){1'b0}}, cur_word};

    // Registered response; load data holds until the next load completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            last_word  <= '0;
        end else begin
            resp_valid <= (accept & ~sub_store) | (state == LSU_RMW_WRITE);
            resp_err   <= accept & trap;
            if (go && !req_we) resp_rdata <= ext_rdata;
            if (ram_read || ram_write) last_word <= cur_word;
        end
    end

    // Capture the old word and store operands for the merge cycle.
    always_ff @(posedge clk) begin
        if (sub_store) begin
            rmw_old   <= ram_readdata;
            rmw_wdata <= req_wdata;
            rmw_word  <= req_word;
            rmw_off   <= req_off;
            rmw_size  <= req_sz;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_address;
    logic        ram_read;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;

    load_store_unit #(.WORD_AW(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .busy          (busy),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .ram_address   (ram_address),
        .ram_read      (ram_read),
        .ram_write     (ram_write),
        .ram_writedata (ram_writedata),
        .ram_readdata  (ram_readdata)
    );

    always #5 clk = ~clk;

    // Environment RAM: combinational read, write on the clock edge.
    logic [31:0] mem [16];
    assign ram_readdata = mem[ram_address[3:0]];
    always @(posedge clk) if (ram_write) mem[ram_address[3:0]] <= ram_writedata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          is_load;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [16];
    int          busy_cyc = -1;
    int          undo_idx = 0;
    logic [31:0] undo_word = 32'h0;
    logic        cap_read, cap_write;
    logic [31:0] cap_addr, cap_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input int sz, input bit sgn);
        logic [31:0] v;
        int n;
        if (sz == 2) return w;
        n = (sz == 0) ? 1 : 2;
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (((w >> (8 * (off + i))) & 32'hFF) << (8 * i));
        if (sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd, input int off, input int sz);
        logic [31:0] r;
        int n;
        n = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        r = old;
        for (int i = 0; i < n; i++) r[8*(off+i) +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // Behavioural effect of one accepted request at the current cycle.
    task automatic model_accept(input bit we, input logic [1:0] size, input bit sgn,
                                input logic [31:0] addr, input logic [31:0] wdata);
        int   sz, off, idx;
        bit   mis;
        exp_t e;
        sz  = (size >= 2) ? 2 : int'(size);
        idx = int'(addr[5:2]);
        mis = (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
`ifdef MISALIGN_TRAP_EN
        if (mis) begin
            e = '{due: cyc + 1, is_load: 1'b0, err: 1'b1, rdata: 32'h0};
            q.push_back(e);
            return;
        end
`endif
        off = int'(addr[1:0]);
        if (sz == 1) off = off & 2;
        if (sz == 2 || mis && sz == 2) off = 0;
        if (!we) begin
            e = '{due: cyc + 1, is_load: 1'b1, err: 1'b0, rdata: model_load(ref_mem[idx], off, sz, sgn)};
        end else if (sz == 2) begin
            ref_mem[idx] = wdata;
            e = '{due: cyc + 1, is_load: 1'b0, err: 1'b0, rdata: 32'h0};
        end else begin
            undo_idx     = idx;
            undo_word    = ref_mem[idx];
            ref_mem[idx] = model_store(ref_mem[idx], wdata, off, sz);
            busy_cyc     = cyc + 1;
            e = '{due: cyc + 2, is_load: 1'b0, err: 1'b0, rdata: 32'h0};
        end
        q.push_back(e);
    endtask

    // Present a request at posedge+1, hold it through any busy cycle, then drop it a cycle later.
    task automatic issue(input bit we, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int tries = 0;
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        while (busy_cyc == cyc && tries < 4) begin
            @(posedge clk); #1;
            tries++;
        end
        model_accept(we, size, sgn, addr, wdata);
        #1;
        cap_read = ram_read; cap_write = ram_write; cap_addr = ram_address; cap_wdata = ram_writedata;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // One-cycle reset from the current cycle; an in-flight merge never lands.
    task automatic reset_now();
        reset = 1'b1;
        if (busy_cyc == cyc) ref_mem[undo_idx] = undo_word;
        while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
        #1;
        cap_write = ram_write;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Per-cycle compare against the model's expected responses.
    bit          armed = 1'b0;
    bit          rst_prev = 1'b0;
    logic [31:0] exp_rd = 32'h0;
    always @(negedge clk) begin
        exp_t e;
        bit   exp_v;
        if (armed) begin
            exp_v = 1'b0;
            if (rst_prev) exp_rd = 32'h0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                exp_v = 1'b1;
                if (e.is_load) exp_rd = e.rdata;
                chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            end
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_v});
            chk("resp_rdata", resp_rdata, exp_rd);
            chk("busy", {31'b0, busy}, {31'b0, (busy_cyc == cyc)});
            chk("strobe_excl", {31'b0, ram_read & ram_write}, 32'h0);
            if (ram_read || ram_write) chk("ram_addr_range", {28'h0, ram_address[31:4] != 28'h0}, 32'h0);
        end
        rst_prev = reset;
        if (reset) armed = 1'b1;
    end

    initial begin
        logic [31:0] r, r2;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = (32'h0101_0101 * i) ^ 32'hA5A5_A5A5;
            ref_mem[i] = (32'h0101_0101 * i) ^ 32'hA5A5_A5A5;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_rdata", resp_rdata, 32'h0);
        chk("reset_valid", {31'b0, resp_valid}, 32'h0);

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        chk("sw_write", {31'b0, cap_write}, 32'h1);
        chk("sw_addr", cap_addr, 32'h4);
        chk("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk("lw_rdata", resp_rdata, 32'hDEAD_BEEF);

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF_7F01);
        issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        chk("lb_signed", resp_rdata, 32'hFFFF_FF80);
        issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        chk("lbu", resp_rdata, 32'h0000_0080);
        issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        chk("lh_signed", resp_rdata, 32'hFFFF_80FF);

        issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
        issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AA);
        chk("sb_read_first", {31'b0, cap_read}, 32'h1);
        chk("sb_busy", {31'b0, busy}, 32'h1);
        chk("sb_rmw_write", {31'b0, ram_write}, 32'h1);
        chk("sb_rmw_addr", ram_address, 32'h4);
        chk("sb_merge", ram_writedata, 32'h1122_AA44);
        @(posedge clk); #1;
        chk("sb_resp", {31'b0, resp_valid}, 32'h1);

        issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        chk("sh_then_lw", resp_rdata, 32'hBEEF_AA44);

        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_F00D);
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_0055);
        reset_now();
        chk("rst_rmw_nowrite", {31'b0, cap_write}, 32'h0);
        chk("rst_busy_clear", {31'b0, busy}, 32'h0);
        chk("rst_no_resp", {31'b0, resp_valid}, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        chk("rst_word_kept", resp_rdata, 32'hCAFE_F00D);

        issue(1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("misalign_err", {31'b0, resp_err}, 32'h1);
        chk("misalign_nostrobe", {31'b0, cap_read | cap_write}, 32'h0);
        chk("misalign_rdata_held", resp_rdata, 32'hCAFE_F00D);
`else
        chk("misalign_err", {31'b0, resp_err}, 32'h0);
        chk("misalign_aligned", resp_rdata, 32'hBEEF_AA44);
`endif

        issue(1'b0, 2'd2, 1'b0, 32'hFFFC_0010, 32'h0);
        chk("wrap_addr", cap_addr, 32'h4);
        chk("wrap_rdata", resp_rdata, 32'hBEEF_AA44);

        for (int n = 0; n < 2500; n++) begin
            r  = $urandom;
            r2 = $urandom;
            if (r[2:0] == 3'd0) begin
                @(posedge clk); #1;
            end else begin
                issue(r[3], r[5:4], r[6], {r2[31:18], 12'h000, r2[5:0]}, $urandom);
                if (r[12:8] == 5'd0 && busy_cyc == cyc) reset_now();
            end
        end

        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);
        chk("queue_drained", q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
